// File: rtl/mp64_alu_wb_pkg.sv
// Shared definitions for the ALU writeback buffer: opcodes, flag bit indices and register-file size.
// The flag sanitiser keeps the reserved flag bits clear everywhere they are stored.
package mp64_alu_wb_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 64;
  localparam int FLAG_W   = 8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_ADC = 4'h1,
    ALU_SUB = 4'h2,
    ALU_SBB = 4'h3,
    ALU_AND = 4'h4,
    ALU_OR  = 4'h5,
    ALU_XOR = 4'h6,
    ALU_NOT = 4'h7,
    ALU_SHL = 4'h8,
    ALU_SHR = 4'h9,
    ALU_SAR = 4'hA,
    ALU_ROL = 4'hB,
    ALU_ROR = 4'hC,
    ALU_CMP = 4'hD,
    ALU_INC = 4'hE,
    ALU_DEC = 4'hF
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;
  localparam int FLAG_G = 5;

  localparam logic [FLAG_W-1:0] FLAG_ARCH_MASK = 8'h3F;

  function automatic logic [FLAG_W-1:0] sanitize_flags(input logic [FLAG_W-1:0] f);
    return f & FLAG_ARCH_MASK;
  endfunction

endpackage

// File: rtl/mp64_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count, flush, and per-slot visibility
// so a wrapper can scan every queued entry (e.g. for register interlocks).
module mp64_sync_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [DEPTH-1:0][WIDTH-1:0] slots,
  output logic [DEPTH-1:0]            slot_valid,
  output logic [CW-1:0]               count,
  output logic                        full,
  output logic                        empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which slots hold live data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign slots = mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
    end
  end

endmodule

// File: rtl/mp64_alu_wb.sv
// In-order ALU writeback buffer: queues results for the register file, commits flags on accept,
// and publishes a pending-destination mask for issue interlocks.
module mp64_alu_wb
  import mp64_alu_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int NREGS = NUM_REGS,
  localparam int DSTW  = $clog2(NREGS),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DSTW-1:0]   in_dst,
  input  logic [DATA_W-1:0] in_result,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [DSTW-1:0]   out_dst,
  output logic [DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0] flags_q,
  input  logic              flags_wr_en,
  input  logic [FLAG_W-1:0] flags_wr_data,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_mask,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic              we;
    logic [DSTW-1:0]   dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               new_entry;
  entry_t               head_raw;
  entry_t               head;
  entry_t [DEPTH-1:0]   slot_e;
  logic   [DEPTH-1:0]   slot_valid;
  logic                 full;
  logic                 empty;
  logic                 accept;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;

  assign new_entry = '{we: (in_op != ALU_CMP), dst: in_dst, data: in_result};

  mp64_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .pop        (out_ready),
    .flush      (flush),
    .wdata      (new_entry),
    .rdata      (head_raw),
    .slots      (slot_e),
    .slot_valid (slot_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Head is forced to zero when empty so unwritten storage never reaches the register file.
  assign head     = out_valid ? head_raw : '0;
  assign out_we   = head.we;
  assign out_dst  = head.dst;
  assign out_data = head.data;

  // External load outranks accept-commit; a flushed accept never commits its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_wr_en) begin
      flags_q <= sanitize_flags(flags_wr_data);
    end else if (accept && !flush) begin
      flags_q <= sanitize_flags(in_flags);
    end
  end

  // NOTE: the default assignment first keeps this combinational block from inferring latches.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && slot_e[i].we) busy_mask[slot_e[i].dst] = 1'b1;
    end
  end

endmodule
